fc_layer_engine: RTL and testbench
==================================

# fc_layer_engine

Parametrised fully-connected layer engine for the LeNet-5 inference path, covering FC1 (400→120), FC2 (120→84) and FC3 (84→10) with one RTL block. It streams an int8 input vector and int8 weights from synchronous 1-cycle-latency RAMs and accumulates in a wide signed register seeded with an int32 bias. It applies an arithmetic right-shift requantisation, then either a tanh LUT or plain int8 clamping, and writes one int8 result per neuron into the next activation buffer.

## Interface
Parameters:
- N_IN, 120: input vector length (≥1)
- N_OUT, 84: neuron count (≥1)
- SHIFT, 9: arithmetic right shift applied to the accumulator before activation
- ACC_W, 32: accumulator width
- IN_AW / W_AW / B_AW / OUT_AW, 7 / 14 / 7 / 7: address widths of the input, weight, bias and output memories
- CLS_W, 7: width of class_idx

Ports:
- clk  in  1  sole clock; all logic on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; accepted only in IDLE
- act_mode  in  1  0 = tanh LUT, 1 = bypass (clamp only); sampled when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write
- in_addr / in_data  out IN_AW / in 8  input vector read port, signed
- w_addr / w_data  out W_AW / in 8  weight read port, signed, row-major [neuron][input]
- b_addr / b_data  out B_AW / in 32  bias read port, signed
- lut_addr / lut_data  out 8 / in 8  tanh LUT read port
- out_addr / out_data / out_wr_en  out OUT_AW / 8 / 1  result write port
- class_idx / class_max  out CLS_W / 8  argmax result (see Configuration)

## Operation
- States: IDLE → BIAS → BIAS_WAIT → MAC → ACT → [LUT_WAIT] → WRITE → BIAS (next neuron) or DONE → IDLE.
- All read ports are synchronous: an address issued in cycle t produces valid data in cycle t+1.
- BIAS: b_addr ← n.
- BIAS_WAIT: acc ← sign-extended b_data; in_addr ← 0; w_addr ← wbase.
- MAC, N_IN cycles, j = 0..N_IN−1:
  - acc ← acc + in_data×w_data, using the operands for index j.
  - Issue addresses for j+1; the value issued on the last cycle is don't-care.
- wbase is a running base: 0 for neuron 0, incremented by N_IN per neuron. No multiplier.
- Accumulator arithmetic is two's complement at ACC_W bits and wraps on overflow; it does not saturate.
- ACT: s = acc >>> SHIFT (arithmetic); c = clamp(s, −128, 127).
  - Tanh mode: lut_addr ← c+128, then LUT_WAIT latches lut_data.
  - Bypass mode: result ← c, and LUT_WAIT is skipped.
- WRITE: out_wr_en=1, out_addr=n, out_data=result, all for exactly one cycle.
- start while busy is ignored. act_mode changes mid-run have no effect.
- Reset, including mid-operation: state IDLE; busy, done, out_wr_en = 0; all address and data outputs = 0; class_idx = 0; class_max = −128. No further write occurs.

## Timing
- Per-neuron period: N_IN+5 cycles in tanh mode, N_IN+4 in bypass mode.
- First BIAS cycle is the cycle after start is accepted.
- Total from start accept to done pulse: N_OUT×(N_IN+5)+1 in tanh mode, N_OUT×(N_IN+4)+1 in bypass mode.
- done is asserted in the cycle after the last out_wr_en. busy drops in that same cycle.
- N_IN=1: MAC lasts one cycle. N_OUT=1: the run goes straight to DONE after the first WRITE.

## Configuration
- FC_ARGMAX_EN defined:
  - class_max and class_idx track the maximum written out_data and its neuron index.
  - Ties keep the lowest index.
  - Both reinitialise (−128 and 0) when start is accepted.
  - Both are stable from the done pulse until the next start.
- FC_ARGMAX_EN undefined: the argmax logic is absent, and class_idx = 0 and class_max = 0 constantly. The ports are kept for interface stability.

## Test plan
- FC2 config (120→84, SHIFT=9, tanh), real FC1 output, weights, biases and LUT → all 84 outputs bit-exact to the golden layer6 data; done at cycle 84×125+1.
- FC3 config (84→10, bypass, FC_ARGMAX_EN) → 10 outputs match golden; class_idx equals the golden predicted digit.
- Saturation: all inputs 127, weights 127, bias 0, N_IN=120 → s=3780 clamps to 127 → lut_addr=255; negated weights → lut_addr=0.
- Argmax tie: outputs {5, 9, 9, −3} in bypass → class_idx=1, class_max=9.
- start pulsed again at MAC cycle 10 of neuron 3 → ignored; write count stays N_OUT; done timing unchanged.
- rst_n low for one cycle during neuron 40 → busy=0, no out_wr_en afterwards; a fresh start then completes correctly.

Source files
------------

// File: rtl/fc_layer_engine.sv
`default_nettype none
// ==========================================================================
// fc_layer_engine : int8 FC layer (bias + MAC, shift requant, tanh LUT/clamp)
// Optional argmax tracking enabled by defining FC_ARGMAX_EN.   Rev 1.0
// ==========================================================================
module fc_layer_engine #(
  parameter int N_IN   = 120,
  parameter int N_OUT  = 84,
  parameter int SHIFT  = 9,
  parameter int ACC_W  = 32,
  parameter int IN_AW  = 7,
  parameter int W_AW   = 14,
  parameter int B_AW   = 7,
  parameter int OUT_AW = 7,
  parameter int CLS_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              act_mode,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [7:0]        in_data,
  output logic [W_AW-1:0]   w_addr,
  input  logic [7:0]        w_data,
  output logic [B_AW-1:0]   b_addr,
  input  logic [31:0]       b_data,
  output logic [7:0]        lut_addr,
  input  logic [7:0]        lut_data,
  output logic [OUT_AW-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic              out_wr_en,
  output logic [CLS_W-1:0]  class_idx,
  output logic [7:0]        class_max
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BIAS  = 3'd1;
  localparam logic [2:0] S_BWAIT = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_ACT   = 3'd4;
  localparam logic [2:0] S_LWAIT = 3'd5;
  localparam logic [2:0] S_WRITE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(-128);

  logic [2:0]              state, state_nx;
  logic [OUT_AW-1:0]       n;
  logic [JW-1:0]           j;
  logic [IN_AW-1:0]        ia;
  logic [W_AW-1:0]         wbase, wa;
  logic signed [ACC_W-1:0] acc, prod_ext, bias_ext, shifted;
  logic signed [15:0]      prod;
  logic signed [7:0]       clamped, result;
  logic                    mode, start_ok, last_in, last_out;

  assign start_ok = (state == S_IDLE) && start;
  assign last_in  = (j == JW'(N_IN - 1));
  assign last_out = (n == OUT_AW'(N_OUT - 1));
  assign prod     = $signed(in_data) * $signed(w_data);
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign shifted  = acc >>> SHIFT;

  generate
    if (ACC_W > 32) begin : g_bias_ext
      assign bias_ext = {{(ACC_W-32){b_data[31]}}, b_data};
    end else if (ACC_W == 32) begin : g_bias_eq
      assign bias_ext = b_data;
    end else begin : g_bias_trunc
      assign bias_ext = b_data[ACC_W-1:0];
    end
  endgenerate

  always_comb begin
    if (shifted > C_MAX)      clamped = 8'h7F;
    else if (shifted < C_MIN) clamped = 8'h80;
    else                      clamped = shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_BIAS;
      S_BIAS:  state_nx = S_BWAIT;
      S_BWAIT: state_nx = S_MAC;
      S_MAC:   if (last_in) state_nx = S_ACT;
      S_ACT:   state_nx = mode ? S_WRITE : S_LWAIT;
      S_LWAIT: state_nx = S_WRITE;
      S_WRITE: state_nx = last_out ? S_DONE : S_BIAS;
      default: state_nx = S_IDLE;
    endcase
  end

  // Read addresses are combinational so data returns in the very next state.
  always_comb begin
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    out_wr_en = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    b_addr    = '0;
    in_addr   = '0;
    w_addr    = '0;
    lut_addr  = '0;
    case (state)
      S_BIAS:  b_addr = B_AW'(n);
      S_BWAIT: w_addr = wbase;
      S_MAC: begin
        in_addr = ia;
        w_addr  = wa;
      end
      S_ACT:   if (!mode) lut_addr = {~clamped[7], clamped[6:0]};
      S_WRITE: begin
        out_wr_en = 1'b1;
        out_addr  = n;
        out_data  = result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n      <= '0;
      j      <= '0;
      ia     <= '0;
      wbase  <= '0;
      wa     <= '0;
      acc    <= '0;
      result <= '0;
      mode   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          n     <= '0;
          wbase <= '0;
          mode  <= act_mode;
        end
        S_BWAIT: begin
          acc <= bias_ext;
          j   <= '0;
          ia  <= IN_AW'(1);
          wa  <= wbase + W_AW'(1);
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          j   <= j + JW'(1);
          ia  <= ia + IN_AW'(1);
          wa  <= wa + W_AW'(1);
        end
        S_ACT:   if (mode) result <= clamped;
        S_LWAIT: result <= lut_data;
        S_WRITE: begin
          n     <= n + OUT_AW'(1);
          wbase <= wbase + W_AW'(N_IN);
        end
        default: ;
      endcase
    end
  end

`ifdef FC_ARGMAX_EN
  logic [CLS_W-1:0]  cidx;
  logic signed [7:0] cmax;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      cidx <= '0;
      cmax <= 8'h80;
    end else if ((state == S_WRITE) && (result > cmax)) begin
      cidx <= CLS_W'(n);
      cmax <= result;
    end
  end

  assign class_idx = cidx;
  assign class_max = cmax;
`else
  assign class_idx = '0;
  assign class_max = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
`default_nettype none
// tb_fc_layer_engine : directed scoreboard bench on a 3-input, 4-neuron, SHIFT=2 instance.
module tb_fc_layer_engine;
  localparam int N_IN  = 3;
  localparam int N_OUT = 4;
  localparam int SHIFT = 2;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, act_mode = 1'b0;
  logic        busy, done, out_wr_en;
  logic [6:0]  in_addr, b_addr, out_addr, class_idx;
  logic [13:0] w_addr;
  logic [7:0]  in_data, w_data, lut_addr, lut_data, out_data, class_max;
  logic [31:0] b_data;

  fc_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT), .ACC_W(32),
    .IN_AW(7), .W_AW(14), .B_AW(7), .OUT_AW(7), .CLS_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_mode(act_mode),
    .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .out_addr(out_addr), .out_data(out_data), .out_wr_en(out_wr_en),
    .class_idx(class_idx), .class_max(class_max)
  );

  always #5 clk = ~clk;

  logic [7:0]  in_mem  [0:127];
  logic [7:0]  w_mem   [0:16383];
  logic [31:0] b_mem   [0:127];
  logic [7:0]  lut_mem [0:255];

  always @(posedge clk) begin
    in_data  <= in_mem[in_addr];
    w_data   <= w_mem[w_addr];
    b_data   <= b_mem[b_addr];
    lut_data <= lut_mem[lut_addr];
  end

  // Data set 0 feeds tests 0 (bypass) and 1 (tanh); data set 1 is the argmax tie case.
  int x_tab [2][3]  = '{'{10, -20, 30}, '{4, 0, 0}};
  int w_tab [2][12] = '{'{1, 2, 3, -1, -1, -1, 127, 127, 127, -128, 0, 0},
                        '{5, 50, -70, 9, -70, 50, 8, 1, 1, -3, 100, -100}};
  int b_tab [2][4]  = '{'{4, -3, 0, -100}, '{0, 0, 4, 0}};
  int exp_out [3][4] = '{'{16, -6, 127, -128}, '{111, -123, 0, -1}, '{5, 9, 9, -3}};
  int exp_idx [3] = '{2, 0, 1};
  int exp_max [3] = '{127, 111, 9};

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t q[$];
  wr_t e;

  int n_vec = 0, n_bad = 0, wr_cnt = 0;

  always @(negedge clk) begin
    if (out_wr_en) begin
      wr_cnt++;
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write got addr=%0d data=%0d, none expected", out_addr, $signed(out_data));
      end else begin
        e = q.pop_front();
        if (out_addr !== e.a || out_data !== e.d) begin
          n_bad++;
          $display("FAIL write got addr=%0d data=%0d expected addr=%0d data=%0d",
                   out_addr, $signed(out_data), e.a, $signed(e.d));
        end
      end
    end
  end

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_class(input int idx, input int mx);
`ifdef FC_ARGMAX_EN
    check("class_idx", 32'(class_idx), idx);
    check("class_max", int'($signed(class_max)), mx);
`else
    check("class_idx_off", 32'(class_idx), 0);
    check("class_max_off", 32'(class_max), 0);
    if (idx < -1000 || mx < -1000) $display("unreachable");
`endif
  endtask

  task automatic load(input int ds);
    for (int i = 0; i < N_IN; i++) in_mem[i] = 8'(x_tab[ds][i]);
    for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = 8'(w_tab[ds][i]);
    for (int i = 0; i < N_OUT; i++) b_mem[i] = 32'(b_tab[ds][i]);
  endtask

  task automatic run(input int tn, input int rep_at, input int abort_at);
    int cnt, base_wr, exp_cyc, done_seen;
    logic m, aborted;
    m = (tn != 1);
    load((tn == 2) ? 1 : 0);
    for (int k = 0; k < N_OUT; k++) q.push_back(wr_t'{a: 7'(k), d: 8'(exp_out[tn][k])});
    base_wr = wr_cnt;
    exp_cyc = N_OUT * (N_IN + (m ? 4 : 5)) + 1;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    act_mode = m;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      act_mode = ~m;
      cnt++;
      if (cnt == 1) check("busy_after_start", 32'(busy), 1);
      if (cnt == rep_at) start = 1'b1;
      if (cnt == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (done || cnt > 200) break;
    end
    if (aborted) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("busy_after_reset", 32'(busy), 0);
      check("wr_en_after_reset", 32'(out_wr_en), 0);
      check_class(0, -128);
      q.delete();
      base_wr = wr_cnt;
      done_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      check("writes_after_reset", wr_cnt - base_wr, 0);
      check("done_after_reset", done_seen, 0);
    end else begin
      check("done_cycle", cnt, exp_cyc);
      check("busy_at_done", 32'(busy), 0);
      check("write_count", wr_cnt - base_wr, N_OUT);
      check_class(exp_idx[tn], exp_max[tn]);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut_mem[i] = ~8'(i);
    for (int i = 0; i < 128; i++) begin
      in_mem[i] = '0;
      b_mem[i]  = '0;
    end
    for (int i = 0; i < 16384; i++) w_mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({busy, done, out_wr_en}), 0);
    check("reset_addr_data", 32'(|{in_addr, w_addr, b_addr, lut_addr, out_addr, out_data}), 0);
    check_class(0, -128);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 0, 0);    // bypass: rounding toward -inf and both clamps
    run(1, 0, 0);    // tanh: LUT addresses 144, 122, 255, 0
    run(2, 0, 0);    // bypass tie {5,9,9,-3}
    run(1, 20, 0);   // second start during neuron 2 MAC
    run(0, 0, 18);   // reset during neuron 2 MAC
    run(0, 0, 0);    // fresh run after the abort
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
